// File: rtl/bram18_byte_packer.sv
// Packs a valid/ready byte stream into 16-bit words with per-byte parity and drives one
// write port of an 18-bit-wide block RAM, with a sequential word pointer, full detection and flush.
module bram18_byte_packer #(
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        CLR,
    input  logic        S_VALID,
    output logic        S_READY,
    input  logic [7:0]  S_DATA,
    input  logic        S_LAST,
    output logic        WEN,
    output logic [1:0]  BE,
    output logic [13:0] ADDR,
    output logic [15:0] WDATA,
    output logic [1:0]  WPARITY,
    output logic [10:0] WORD_COUNT,
    output logic        FULL,
    output logic        DONE
);

    localparam logic [10:0] DepthW = 11'(DEPTH);
    localparam logic        PBit   = (PARITY_ODD != 0);

    typedef enum logic {StEmpty, StHold} state_e;

    state_e      state_q, state_d;
    logic [7:0]  low_q, low_d;
    logic        wen_q, wen_d;
    logic [1:0]  be_q, be_d;
    logic [13:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [1:0]  wparity_q, wparity_d;
    logic [10:0] count_q, count_d;
    logic        full_q, full_d;
    logic        done_q, done_d;
    logic [10:0] count_inc;
    logic        hs;

    // FULL is registered together with the write that fills the last slot, so the
    // slot can never be over-committed by a following byte.
    assign S_READY = RST_N & ~full_q & ~CLR;
    assign hs      = S_VALID & S_READY;

    always_comb begin
        state_d   = state_q;
        low_d     = low_q;
        wen_d     = 1'b0;
        be_d      = be_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wparity_d = wparity_q;
        count_d   = count_q;
        full_d    = full_q;
        done_d    = 1'b0;
        count_inc = count_q + 11'd1;

        if (CLR) begin
            state_d = StEmpty;
            count_d = '0;
            full_d  = 1'b0;
        end else if (hs) begin
            if (state_q == StEmpty && !S_LAST) begin
                low_d   = S_DATA;
                state_d = StHold;
            end else begin
                wen_d   = 1'b1;
                done_d  = S_LAST;
                addr_d  = {count_q[9:0], 4'h0};
                count_d = count_inc;
                full_d  = (count_inc == DepthW);
                state_d = StEmpty;
                if (state_q == StHold) begin
                    be_d      = 2'b11;
                    wdata_d   = {S_DATA, low_q};
                    wparity_d = {^S_DATA ^ PBit, ^low_q ^ PBit};
                end else begin
                    be_d      = 2'b01;
                    wdata_d   = {8'h00, S_DATA};
                    wparity_d = {PBit, ^S_DATA ^ PBit};
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q   <= StEmpty;
            low_q     <= '0;
            wen_q     <= 1'b0;
            be_q      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wparity_q <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            low_q     <= low_d;
            wen_q     <= wen_d;
            be_q      <= be_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wparity_q <= wparity_d;
            count_q   <= count_d;
            full_q    <= full_d;
            done_q    <= done_d;
        end
    end

    assign WEN        = wen_q;
    assign BE         = be_q;
    assign ADDR       = addr_q;
    assign WDATA      = wdata_q;
    assign WPARITY    = wparity_q;
    assign WORD_COUNT = count_q;
    assign FULL       = full_q;
    assign DONE       = done_q;

endmodule
